// File: rtl/led_breather_pkg.sv
// led_breather_pkg: ramp state encoding and default PWM width shared by the breather blocks
package led_breather_pkg;
  localparam int PWM_BITS_DEF = 8;
  typedef enum logic [1:0] {
    ST_RAMP_UP   = 2'd0,
    ST_HOLD_HI   = 2'd1,
    ST_RAMP_DOWN = 2'd2,
    ST_HOLD_LO   = 2'd3
  } state_e;
endpackage

// File: rtl/led_breather_pwm_gen.sv
// pwm_gen: free-running PWM counter with period-boundary duty latch and registered complementary outputs
module pwm_gen
  import led_breather_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [PWM_BITS-1:0] duty,
  output logic                out_a,
  output logic                out_b
);
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d, duty_act_q, duty_act_d;
  logic                out_a_q, out_a_d, out_b_q, out_b_d;
  always_comb begin
    pwm_cnt_d  = enable ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
    duty_act_d = (enable && (&pwm_cnt_q)) ? duty : duty_act_q;
    out_a_d    = enable && (pwm_cnt_q < duty_act_q);
    out_b_d    = enable && (pwm_cnt_q < ~duty_act_q);
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pwm_cnt_q  <= '0;
      duty_act_q <= '0;
      out_a_q    <= 1'b0;
      out_b_q    <= 1'b0;
    end else begin
      pwm_cnt_q  <= pwm_cnt_d;
      duty_act_q <= duty_act_d;
      out_a_q    <= out_a_d;
      out_b_q    <= out_b_d;
    end
  end
  assign out_a = out_a_q;
  assign out_b = out_b_q;
endmodule

// File: rtl/led_breather.sv
// led_breather: tick-paced ramp FSM sweeping a PWM duty up/hold/down/hold onto two complementary LEDs
module led_breather
  import led_breather_pkg::*;
#(
  parameter int PWM_BITS   = PWM_BITS_DEF,
  parameter int HOLD_TICKS = 64,
  parameter int HOLD_BITS  = 7
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                tick,
  input  logic                enable,
  output logic [1:0]          led,
  output logic [PWM_BITS-1:0] level,
  output logic                busy_up
);
  localparam logic [PWM_BITS-1:0]  DUTY_TOP  = PWM_BITS'((1 << PWM_BITS) - 2);
  localparam logic [PWM_BITS-1:0]  DUTY_ONE  = PWM_BITS'(1);
  localparam logic [HOLD_BITS-1:0] HOLD_LAST = HOLD_BITS'(HOLD_TICKS - 1);
  state_e              state_q, state_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [HOLD_BITS-1:0] hold_cnt_q, hold_cnt_d;
  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    hold_cnt_d = hold_cnt_q;
    if (tick && enable) begin
      case (state_q)
        ST_RAMP_UP: begin
          duty_d = duty_q + 1'b1;
          if (duty_q == DUTY_TOP) begin
            state_d    = ST_HOLD_HI;
            hold_cnt_d = '0;
          end
        end
        ST_HOLD_HI: begin
          hold_cnt_d = hold_cnt_q + 1'b1;
          if (hold_cnt_q == HOLD_LAST) state_d = ST_RAMP_DOWN;
        end
        ST_RAMP_DOWN: begin
          duty_d = duty_q - 1'b1;
          if (duty_q == DUTY_ONE) begin
            state_d    = ST_HOLD_LO;
            hold_cnt_d = '0;
          end
        end
        ST_HOLD_LO: begin
          hold_cnt_d = hold_cnt_q + 1'b1;
          if (hold_cnt_q == HOLD_LAST) state_d = ST_RAMP_UP;
        end
        default: begin
          state_d = ST_RAMP_UP;
          duty_d  = '0;
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_RAMP_UP;
      duty_q     <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end
  assign level   = duty_q;
  assign busy_up = (state_q == ST_RAMP_UP) || (state_q == ST_HOLD_HI);
  pwm_gen #(.PWM_BITS(PWM_BITS)) u_pwm (
    .clk    (clk),
    .reset_n(reset_n),
    .enable (enable),
    .duty   (duty_q),
    .out_a  (led[0]),
    .out_b  (led[1])
  );
endmodule

// File: tb/tb_led_breather.sv
// tb_led_breather: randomized tick/enable stimulus checked every cycle against a step-position model of the breathing cycle
module tb_led_breather;
  logic       clk = 1'b0;
  logic       reset_n, tick, enable;
  logic [1:0] led;
  logic [7:0] level;
  logic       busy_up;
  int compared = 0, mismatched = 0;
  int mp, mcnt, mdact;
  bit ea, eb, na, nb, valid = 1'b0;
  led_breather dut (
    .clk    (clk),
    .reset_n(reset_n),
    .tick   (tick),
    .enable (enable),
    .led    (led),
    .level  (level),
    .busy_up(busy_up)
  );
  always #5 clk = ~clk;
  // Position in the 638-step breathing cycle fully determines duty and direction.
  function automatic int lvl(input int p);
    return p < 255 ? p : p < 319 ? 255 : p < 574 ? 574 - p : 0;
  endfunction
  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    if (!reset_n) begin
      mp = 0; mcnt = 0; mdact = 0; ea = 0; eb = 0; valid = 1'b1;
    end else begin
      na = enable && (mcnt < mdact);
      nb = enable && (mcnt < 255 - mdact);
      if (enable && mcnt == 255) mdact = lvl(mp);
      if (enable) mcnt = (mcnt + 1) % 256;
      if (tick && enable) mp = (mp + 1) % 638;
      ea = na; eb = nb;
    end
  end
  always @(negedge clk) begin
    if (valid) begin
      chk("led", int'(led), int'({eb, ea}));
      chk("level", int'(level), lvl(mp));
      chk("busy_up", int'(busy_up), int'(mp < 319));
    end
  end
  task automatic ticks(input int n);
    repeat (n) begin
      tick = 1'b1; enable = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask
  task automatic period(input int tick_at, output int c0, output int c1);
    int k = 0;
    tick = 1'b0; enable = 1'b1; c0 = 0; c1 = 0;
    while (mcnt != 1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) chk("period_align_timeout", k, 0);
    for (int i = 0; i < 256; i++) begin
      c0 += int'(led[0]);
      c1 += int'(led[1]);
      tick = (mcnt == tick_at);
      @(negedge clk);
    end
    tick = 1'b0;
  endtask
  initial begin
    int c0, c1, k;
    reset_n = 1'b0; enable = 1'b1; tick = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_led", int'(led), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_busy", int'(busy_up), 1);
    chk("rst_model_cnt", mcnt, 0);
    reset_n = 1'b1; tick = 1'b0;
    ticks(255);
    chk("up_level", int'(level), 255);
    chk("up_busy", int'(busy_up), 1);
    chk("up_model_pos", mp, 255);
    ticks(64);
    chk("hold_hi_level", int'(level), 255);
    chk("hold_hi_busy", int'(busy_up), 0);
    ticks(255);
    chk("down_level", int'(level), 0);
    chk("down_busy", int'(busy_up), 0);
    ticks(64);
    chk("wrap_level", int'(level), 0);
    chk("wrap_busy", int'(busy_up), 1);
    chk("wrap_model_pos", mp, 0);
    ticks(64);
    tick = 1'b0;
    repeat (512) @(negedge clk);
    period(-1, c0, c1);
    chk("duty64_led0", c0, 64);
    chk("duty64_led1", c1, 191);
    period(10, c0, c1);
    chk("glitch_cur_led0", c0, 64);
    chk("glitch_level", int'(level), 65);
    period(-1, c0, c1);
    chk("glitch_next_led0", c0, 65);
    chk("glitch_next_led1", c1, 190);
    ticks(35);
    chk("freeze_pre_level", int'(level), 100);
    enable = 1'b0; tick = 1'b1;
    repeat (20) @(negedge clk);
    tick = 1'b0;
    chk("freeze_level", int'(level), 100);
    chk("freeze_led", int'(led), 0);
    ticks(1);
    chk("resume_level", int'(level), 101);
    repeat (3000) begin
      tick = ($urandom_range(0, 3) == 0);
      enable = ($urandom_range(0, 7) != 0);
      @(negedge clk);
    end
    enable = 1'b1; tick = 1'b1; k = 0;
    while (mp != 374 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    tick = 1'b0;
    chk("mid_level", int'(level), 200);
    chk("mid_busy", int'(busy_up), 0);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("mid_rst_level", int'(level), 0);
    chk("mid_rst_busy", int'(busy_up), 1);
    ticks(1);
    chk("mid_rst_first_tick", int'(level), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
